// File: rtl/phase_select_filter.sv
// -----------------------------------------------------------------------------
// phase_select_filter
//
// Digital loop filter for a bang-bang CDR. Every accepted detector strobe adds
// a vote to a small signed accumulator: +1 for an up-only vote, -1 for a
// down-only vote, and 0 for a tie or no vote. When the accumulator reaches
// +THRESH or -THRESH it is cleared and the multiphase clock index moves one
// step in that direction, wrapping at either end. A saturating counter of
// step-free strobes drives the lock indicator.
//
// Ports
//   clk        in   system clock, all state on posedge
//   rst        in   synchronous active-high reset
//   up, down   in   detector votes, sampled only while pd_valid=1
//   pd_valid   in   one-cycle strobe qualifying up/down
//   freeze     in   1 = hold accumulator, phase index and lock state
//   phase_sel  out  registered phase index, 0..NUM_PHASES-1
//   step_up    out  one-cycle pulse on the edge that increments phase_sel
//   step_dn    out  one-cycle pulse on the edge that decrements phase_sel
//   locked     out  registered lock indicator
// -----------------------------------------------------------------------------
module phase_select_filter #(
  parameter int NUM_PHASES = 8,
  parameter int PHASE_W    = 3,
  parameter int INIT_PHASE = 0,
  parameter int THRESH     = 4,
  parameter int CNT_W      = 4,
  parameter int LOCK_COUNT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up,
  input  logic               down,
  input  logic               pd_valid,
  input  logic               freeze,
  output logic [PHASE_W-1:0] phase_sel,
  output logic               step_up,
  output logic               step_dn,
  output logic               locked
);

  // The quiet counter must be able to hold LOCK_COUNT itself.
  localparam int QUIET_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [PHASE_W-1:0]      LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [PHASE_W-1:0]      INIT_SEL   = PHASE_W'(INIT_PHASE);
  localparam logic signed [CNT_W-1:0] POS_THRESH = CNT_W'(THRESH);
  localparam logic signed [CNT_W-1:0] NEG_THRESH = CNT_W'(-THRESH);
  localparam logic [QUIET_W-1:0]      QUIET_MAX  = QUIET_W'(LOCK_COUNT);

  // State
  logic signed [CNT_W-1:0] acc_q,     acc_d;
  logic [PHASE_W-1:0]      phase_q,   phase_d;
  logic                    step_up_q, step_up_d;
  logic                    step_dn_q, step_dn_d;
  logic [QUIET_W-1:0]      quiet_q,   quiet_d;
  logic                    locked_q,  locked_d;

  // Combinational helpers
  logic                    accept;
  logic signed [CNT_W-1:0] vote;
  logic signed [CNT_W-1:0] acc_sum;
  logic                    hit_pos;
  logic                    hit_neg;
  logic [PHASE_W-1:0]      phase_inc;
  logic [PHASE_W-1:0]      phase_dec;
  logic [QUIET_W-1:0]      quiet_inc;

  // ---------------------------------------------------------------------------
  // Vote decode and accumulator sum
  // ---------------------------------------------------------------------------
  always_comb begin
    accept = pd_valid & ~freeze;

    // Ties and empty votes contribute nothing but still count as a strobe.
    vote = '0;
    if (up && !down) begin
      vote = CNT_W'(1);
    end else if (down && !up) begin
      vote = '1;                       // -1 in two's complement
    end

    // CNT_W is wide enough for +/-THRESH, and acc_q never leaves the open
    // interval (-THRESH, +THRESH), so this sum cannot wrap.
    acc_sum = acc_q + vote;
    hit_pos = (acc_sum == POS_THRESH);
    hit_neg = (acc_sum == NEG_THRESH);
  end

  // ---------------------------------------------------------------------------
  // Phase index neighbours with modular wrap. NUM_PHASES need not be a power
  // of two, so the wrap is an explicit compare rather than natural overflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_inc = (phase_q == LAST_PHASE) ? '0 : phase_q + PHASE_W'(1);
    phase_dec = (phase_q == '0) ? LAST_PHASE : phase_q - PHASE_W'(1);
  end

  // Saturating increment of the step-free strobe run.
  always_comb begin
    quiet_inc = (quiet_q >= QUIET_MAX) ? QUIET_MAX : quiet_q + QUIET_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d     = acc_q;
    phase_d   = phase_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    quiet_d   = quiet_q;
    locked_d  = locked_q;

    if (accept) begin
      if (hit_pos) begin
        acc_d     = '0;
        phase_d   = phase_inc;
        step_up_d = 1'b1;
      end else if (hit_neg) begin
        acc_d     = '0;
        phase_d   = phase_dec;
        step_dn_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end

      // Any phase step breaks the quiet run and drops lock immediately.
      if (hit_pos || hit_neg) begin
        quiet_d  = '0;
        locked_d = 1'b0;
      end else begin
        quiet_d = quiet_inc;
        if (quiet_inc == QUIET_MAX) begin
          locked_d = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      phase_q   <= INIT_SEL;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      quiet_q   <= '0;
      locked_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      quiet_q   <= quiet_d;
      locked_q  <= locked_d;
    end
  end

  assign phase_sel = phase_q;
  assign step_up   = step_up_q;
  assign step_dn   = step_dn_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_phase_select_filter.sv
// -----------------------------------------------------------------------------
// tb_phase_select_filter
//
// Two instances: the default 8-phase filter (INIT_PHASE=0) and a 6-phase
// filter starting at phase 5. The driver applies one directed vector per
// clock to one instance and pushes the hand-computed outputs expected after
// that edge onto a queue; a separate monitor pops one entry per edge and
// compares it against the addressed instance.
// -----------------------------------------------------------------------------
module tb_phase_select_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-phase instance
  logic       rst8 = 1'b1, up8 = 1'b0, dn8 = 1'b0, v8 = 1'b0, f8 = 1'b0;
  logic [2:0] ph8;
  logic       su8, sd8, lk8;

  // 6-phase instance
  logic       rst6 = 1'b1, up6 = 1'b0, dn6 = 1'b0, v6 = 1'b0, f6 = 1'b0;
  logic [2:0] ph6;
  logic       su6, sd6, lk6;

  phase_select_filter dut8 (
    .clk(clk), .rst(rst8), .up(up8), .down(dn8), .pd_valid(v8), .freeze(f8),
    .phase_sel(ph8), .step_up(su8), .step_dn(sd8), .locked(lk8)
  );

  phase_select_filter #(
    .NUM_PHASES(6), .PHASE_W(3), .INIT_PHASE(5), .THRESH(4), .CNT_W(4), .LOCK_COUNT(16)
  ) dut6 (
    .clk(clk), .rst(rst6), .up(up6), .down(dn6), .pd_valid(v6), .freeze(f6),
    .phase_sel(ph6), .step_up(su6), .step_dn(sd6), .locked(lk6)
  );

  typedef struct {
    int id;
    bit sel6;
    int ph;
    bit su;
    bit sd;
    bit lk;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   txn_id     = 0;

  task automatic check(input string name, input int id, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s txn=%0d got=%0d expected=%0d", name, id, got, want);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled 2 time units after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        #2;
        if (e.sel6) begin
          $display("txn %0d dut6: phase=%0d step_up=%0d step_dn=%0d locked=%0d", e.id, ph6, su6, sd6, lk6);
          check("phase6",   e.id, int'(ph6), e.ph);
          check("step_up6", e.id, int'(su6), int'(e.su));
          check("step_dn6", e.id, int'(sd6), int'(e.sd));
          check("locked6",  e.id, int'(lk6), int'(e.lk));
        end else begin
          $display("txn %0d dut8: phase=%0d step_up=%0d step_dn=%0d locked=%0d", e.id, ph8, su8, sd8, lk8);
          check("phase8",   e.id, int'(ph8), e.ph);
          check("step_up8", e.id, int'(su8), int'(e.su));
          check("step_dn8", e.id, int'(sd8), int'(e.sd));
          check("locked8",  e.id, int'(lk8), int'(e.lk));
        end
      end
    end
  end

  // Drive one cycle on the 8-phase instance; the 6-phase one idles.
  task automatic d8(input logic r, input logic u, input logic d, input logic v, input logic f,
                    input int ph, input bit su, input bit sd, input bit lk);
    exp_t e;
    @(posedge clk);
    #1;
    rst8 = r; up8 = u; dn8 = d; v8 = v; f8 = f;
    rst6 = 1'b0; v6 = 1'b0; f6 = 1'b0; up6 = 1'b0; dn6 = 1'b0;
    e.id = txn_id; e.sel6 = 1'b0; e.ph = ph; e.su = su; e.sd = sd; e.lk = lk;
    sb.push_back(e);
    txn_id++;
  endtask

  // Drive one cycle on the 6-phase instance; the 8-phase one idles.
  task automatic d6(input logic r, input logic u, input logic d, input logic v, input logic f,
                    input int ph, input bit su, input bit sd, input bit lk);
    exp_t e;
    @(posedge clk);
    #1;
    rst6 = r; up6 = u; dn6 = d; v6 = v; f6 = f;
    rst8 = 1'b0; v8 = 1'b0; f8 = 1'b0; up8 = 1'b0; dn8 = 1'b0;
    e.id = txn_id; e.sel6 = 1'b1; e.ph = ph; e.su = su; e.sd = sd; e.lk = lk;
    sb.push_back(e);
    txn_id++;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with random inputs, then three up votes must not step
    repeat (2) d8(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, 0);
    repeat (3) d8(0, 1, 0, 1, 0, 0, 0, 0, 0);

    // 2: increment on the 4th up only, then 3 more ups with no step
    d8(1, 1, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) d8(0, 1, 0, 1, 0, 0, 0, 0, 0);
    d8(0, 1, 0, 1, 0, 1, 1, 0, 0);
    repeat (3) d8(0, 1, 0, 1, 0, 1, 0, 0, 0);
    d8(0, 0, 0, 0, 0, 1, 0, 0, 0);

    // 3: wrap 0->7 down, 7->0 up, 0->7 down again
    d8(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) d8(0, 0, 1, 1, 0, 0, 0, 0, 0);
    d8(0, 0, 1, 1, 0, 7, 0, 1, 0);
    repeat (3) d8(0, 1, 0, 1, 0, 7, 0, 0, 0);
    d8(0, 1, 0, 1, 0, 0, 1, 0, 0);
    repeat (3) d8(0, 0, 1, 1, 0, 0, 0, 0, 0);
    d8(0, 0, 1, 1, 0, 7, 0, 1, 0);

    // 3b: six phases starting at 5: 5->0 up, 0->5 down
    d6(1, 0, 0, 0, 0, 5, 0, 0, 0);
    repeat (3) d6(0, 1, 0, 1, 0, 5, 0, 0, 0);
    d6(0, 1, 0, 1, 0, 0, 1, 0, 0);
    repeat (3) d6(0, 0, 1, 1, 0, 0, 0, 0, 0);
    d6(0, 0, 1, 1, 0, 5, 0, 1, 0);

    // 4: cancellation and ties, then up x3 / down x7.
    // The quiet run reaches 16 on the 6th down; the 7th down steps and unlocks.
    d8(1, 0, 0, 0, 0, 0, 0, 0, 0);
    d8(0, 1, 0, 1, 0, 0, 0, 0, 0);
    d8(0, 0, 1, 1, 0, 0, 0, 0, 0);
    d8(0, 1, 0, 1, 0, 0, 0, 0, 0);
    d8(0, 0, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) d8(0, 1, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) d8(0, 1, 0, 1, 0, 0, 0, 0, 0);
    repeat (5) d8(0, 0, 1, 1, 0, 0, 0, 0, 0);
    d8(0, 0, 1, 1, 0, 0, 0, 0, 1);
    d8(0, 0, 1, 1, 0, 7, 0, 1, 0);

    // 5: lock after 16 alternating strobes; freeze and idle hold it;
    //    the 4th up steps and drops lock
    d8(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      d8(0, (i % 2) == 0, (i % 2) == 1, 1, 0, 0, 0, 0, i == 15);
    end
    repeat (2) d8(0, 1, 0, 1, 1, 0, 0, 0, 1);
    d8(0, 1, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) d8(0, 1, 0, 1, 0, 0, 0, 0, 1);
    d8(0, 1, 0, 1, 0, 1, 1, 0, 0);
    d8(0, 1, 0, 1, 0, 1, 0, 0, 0);

    // 6: freeze holds acc=3; next live up steps. Then mid-accumulation reset.
    d8(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) d8(0, 1, 0, 1, 0, 0, 0, 0, 0);
    repeat (5) d8(0, 1, 0, 1, 1, 0, 0, 0, 0);
    repeat (2) d8(0, 1, 0, 0, 0, 0, 0, 0, 0);
    d8(0, 1, 0, 1, 0, 1, 1, 0, 0);
    repeat (3) d8(0, 1, 0, 1, 0, 1, 0, 0, 0);
    d8(1, 1, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) d8(0, 1, 0, 1, 0, 0, 0, 0, 0);
    d8(0, 1, 0, 1, 0, 1, 1, 0, 0);

    // Drain the scoreboard with a bounded wait.
    @(posedge clk);
    #1;
    v8 = 1'b0; up8 = 1'b0; dn8 = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
